keccak_squeeze_unit: RTL and testbench
======================================

Name: keccak_squeeze_unit

Overview:
- Output (squeeze) side of the Keccak engine. Absorb packs input words into the state; this block reads the rate portion of the permuted state back out.
- Emits a packed byte stream of DWIDTH-bit beats with per-byte keep.
- For SHAKE lengths longer than one rate block, it requests further permutations and carries leftover rate bytes across block boundaries.

Parameters:
- DWIDTH, 256, output beat width in bits (32 bytes).
- STATE_WIDTH, 1600, Keccak state width (25 lanes x 64).
- RATE_WIDTH, 11, width of rate_i.
- CARRY_WIDTH, 192, carry buffer for rate tail bytes (24 bytes).
- OUT_LEN_WIDTH, 16, width of requested output length in bytes.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle pulse that begins a squeeze. Sampled in IDLE only.
- rate_i  in  RATE_WIDTH  rate in bits; legal values are 576, 1088, 1344. Sampled with start_i.
- out_len_i  in  OUT_LEN_WIDTH  total output bytes. Sampled with start_i.
- state_i  in  STATE_WIDTH  flattened state. Rate byte i = state_i[8*i +: 8].
- state_valid_i  in  1  pulse: permutation finished, state_i valid this cycle.
- perm_req_o  out  1  one-cycle pulse requesting one more permutation.
- m_axis_tdata_o  out  DWIDTH  output bytes; byte k = tdata[8k +: 8].
- m_axis_tkeep_o  out  DWIDTH/8  byte-valid mask, contiguous from bit 0.
- m_axis_tvalid_o  out  1  beat valid.
- m_axis_tready_i  in  1  downstream ready.
- m_axis_tlast_o  out  1  final beat of the digest.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, internal counters, carry buffer and rate snapshot cleared. A reset mid-operation aborts immediately; no partial beat is held afterwards.
- Internal registers:
  - rate_bytes = rate_i/8.
  - remain: bytes still to emit.
  - offset: next unread rate byte.
  - carry_len: 0..24 bytes.
  - rate_buf: rate snapshot, 1344 bits.
- IDLE:
  - start_i latches rate_bytes and remain = out_len_i, then goes to WAIT_STATE.
  - If out_len_i == 0, go instead to FINISH and emit no beats.
  - start_i while busy is ignored.
- WAIT_STATE:
  - On state_valid_i, copy the rate portion of state_i into rate_buf, set offset = 0, go to EMIT.
  - The first tvalid is asserted the cycle after the capture.
  - state_valid_i in any other state is ignored.
- EMIT:
  - avail = carry_len + (rate_bytes - offset).
  - n = min(32, remain).
  - If avail >= n, present a beat:
    - bytes [0, carry_len) come from the carry buffer;
    - bytes [carry_len, n) come from rate_buf starting at offset;
    - bytes n..31 are zero;
    - tkeep = (1<<n)-1;
    - tlast = (remain <= 32).
  - If avail < n:
    - move the rate tail (rate_bytes - offset bytes) into the carry buffer after any existing carry;
    - carry_len += that count;
    - pulse perm_req_o for one cycle;
    - go to WAIT_STATE. No beat is presented that cycle.
- Handshake (tvalid & tready):
  - remain -= n.
  - offset += n - carry_len.
  - carry_len = 0.
  - If tlast, go to FINISH.
  - If offset == rate_bytes and remain > 0, pulse perm_req_o and go to WAIT_STATE.
- Stability: while tvalid is high and tready is low, tdata, tkeep and tlast are held stable. tvalid never drops before the handshake.
- FINISH: done_o = 1 for one cycle, then IDLE.
- Boundary cases:
  - For supported rates, rate_bytes mod 32 = 8, so carry_len never exceeds 24.
  - out_len equal to rate_bytes needs no permutation request.
  - perm_req_o is never asserted in the same cycle as tvalid.

Test Plan:
- SHA3-256: rate 1088, len 32, state bytes = index -> one beat, tdata bytes 0x00..0x1F, tkeep=0xFFFFFFFF, tlast=1, no perm_req_o, done_o one cycle after accept.
- SHA3-512: rate 576, len 64 -> two beats (bytes 0..31, then 32..63), tlast only on beat 2, no perm_req_o.
- SHAKE128: rate 1344, len 200, second state bytes = 0x80+index:
  - beats 1-5 = bytes 0..159;
  - then one perm_req_o pulse; supply the second state;
  - beat 6 = old bytes 160..167 followed by new 0x80..0x97, full keep;
  - beat 7 = 0x98..0x9F, tkeep=0xFF, tlast.
- SHAKE256: rate 1088, len 136 -> 4 full beats plus beat 5 with 8 bytes, tkeep=0xFF, tlast, no perm_req_o.
- Backpressure: random tready low on the SHAKE128 case -> tdata/tkeep/tlast stable while stalled, byte sequence unchanged.
- Edge: len 0 -> done_o pulse, tvalid never high. rst_n low mid-beat -> all outputs 0, busy_o=0, and the next start_i runs a clean digest.

Source files
------------

// File: rtl/keccak_squeeze_unit.sv
// Squeeze side of the Keccak engine: streams the rate part of the permuted state as
// packed DWIDTH-bit beats, requesting extra permutations for outputs longer than a block.
module keccak_squeeze_unit #(
    parameter int DWIDTH        = 256,
    parameter int STATE_WIDTH   = 1600,
    parameter int RATE_WIDTH    = 11,
    parameter int CARRY_WIDTH   = 192,
    parameter int OUT_LEN_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic [RATE_WIDTH-1:0]    rate_i,
    input  logic [OUT_LEN_WIDTH-1:0] out_len_i,
    input  logic [STATE_WIDTH-1:0]   state_i,
    input  logic                     state_valid_i,
    output logic                     perm_req_o,
    output logic [DWIDTH-1:0]        m_axis_tdata_o,
    output logic [DWIDTH/8-1:0]      m_axis_tkeep_o,
    output logic                     m_axis_tvalid_o,
    input  logic                     m_axis_tready_i,
    output logic                     m_axis_tlast_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int BEAT_BYTES     = DWIDTH / 8;
    localparam int RATE_MAX       = 1344;
    localparam int RATE_MAX_BYTES = RATE_MAX / 8;
    localparam int CARRY_BYTES    = CARRY_WIDTH / 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_EMIT   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t                   state_r;
    logic [7:0]               rate_bytes_r;
    logic [OUT_LEN_WIDTH-1:0] remain_r;
    logic [7:0]               offset_r;
    logic [4:0]               carry_len_r;
    logic [CARRY_WIDTH-1:0]   carry_buf_r;
    logic [RATE_MAX-1:0]      rate_buf_r;
    logic                     perm_req_r;
    logic                     done_r;

    logic [6:0]               n_s;
    logic [8:0]               avail_s;
    logic                     beat_valid_s;
    logic                     last_s;
    logic [RATE_MAX-1:0]      shifted_s;
    logic [DWIDTH-1:0]        merged_s;
    logic [DWIDTH-1:0]        data_s;
    logic [BEAT_BYTES-1:0]    keep_s;
    logic [7:0]               tail_len_s;
    logic [CARRY_WIDTH-1:0]   tail_s;
    logic [CARRY_WIDTH-1:0]   carry_next_s;
    logic [RATE_MAX-1:0]      rate_mask_s;
    logic [7:0]               offset_adv_s;
    logic [OUT_LEN_WIDTH-1:0] remain_left_s;
    logic                     unused_s;

    // Beat assembly: carry bytes first, then rate bytes from offset, zero above n.
    always_comb begin
        n_s           = (remain_r >= OUT_LEN_WIDTH'(BEAT_BYTES)) ? 7'(BEAT_BYTES) : remain_r[6:0];
        avail_s       = 9'(carry_len_r) + 9'(rate_bytes_r) - 9'(offset_r);
        beat_valid_s  = (state_r == S_EMIT) && (avail_s >= 9'(n_s));
        last_s        = beat_valid_s && (remain_r <= OUT_LEN_WIDTH'(BEAT_BYTES));
        shifted_s     = rate_buf_r >> {offset_r, 3'b000};
        merged_s      = (shifted_s[DWIDTH-1:0] << {carry_len_r, 3'b000}) | DWIDTH'(carry_buf_r);
        offset_adv_s  = offset_r + 8'(n_s) - 8'(carry_len_r);
        remain_left_s = remain_r - OUT_LEN_WIDTH'(n_s);
        tail_len_s    = rate_bytes_r - offset_r;
        keep_s        = '0;
        data_s        = '0;
        tail_s        = '0;
        rate_mask_s   = '0;
        for (int k = 0; k < BEAT_BYTES; k++) begin
            keep_s[k]        = beat_valid_s && (7'(k) < n_s);
            data_s[8*k +: 8] = keep_s[k] ? merged_s[8*k +: 8] : 8'h00;
        end
        for (int k = 0; k < CARRY_BYTES; k++) begin
            tail_s[8*k +: 8] = (8'(k) < tail_len_s) ? shifted_s[8*k +: 8] : 8'h00;
        end
        // Unused rate bytes are cleared on capture so stale state never leaks out.
        for (int i = 0; i < RATE_MAX_BYTES; i++) begin
            rate_mask_s[8*i +: 8] = (8'(i) < rate_bytes_r) ? 8'hFF : 8'h00;
        end
        carry_next_s = carry_buf_r | (tail_s << {carry_len_r, 3'b000});
    end

    // Squeeze FSM with its counters, carry buffer and rate snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            rate_bytes_r <= 8'd0;
            remain_r     <= '0;
            offset_r     <= 8'd0;
            carry_len_r  <= 5'd0;
            carry_buf_r  <= '0;
            rate_buf_r   <= '0;
            perm_req_r   <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            perm_req_r <= 1'b0;
            done_r     <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start_i) begin
                        rate_bytes_r <= 8'(rate_i >> 3);
                        remain_r     <= out_len_i;
                        offset_r     <= 8'd0;
                        carry_len_r  <= 5'd0;
                        carry_buf_r  <= '0;
                        if (out_len_i == '0) begin
                            state_r <= S_FINISH;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (state_valid_i) begin
                        rate_buf_r <= state_i[RATE_MAX-1:0] & rate_mask_s;
                        offset_r   <= 8'd0;
                        state_r    <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (beat_valid_s) begin
                        if (m_axis_tready_i) begin
                            remain_r    <= remain_left_s;
                            offset_r    <= offset_adv_s;
                            carry_len_r <= 5'd0;
                            carry_buf_r <= '0;
                            if (last_s) begin
                                state_r <= S_FINISH;
                                done_r  <= 1'b1;
                            end else if ((offset_adv_s == rate_bytes_r) && (remain_left_s != '0)) begin
                                perm_req_r <= 1'b1;
                                state_r    <= S_WAIT;
                            end
                        end
                    end else begin
                        // Not enough bytes left in this block: park the tail and fetch the next one.
                        carry_buf_r <= carry_next_s;
                        carry_len_r <= carry_len_r + tail_len_s[4:0];
                        offset_r    <= rate_bytes_r;
                        perm_req_r  <= 1'b1;
                        state_r     <= S_WAIT;
                    end
                end
                S_FINISH: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign unused_s        = ^{rate_i[2:0], state_i[STATE_WIDTH-1:RATE_MAX]};
    assign perm_req_o      = perm_req_r;
    assign done_o          = done_r;
    assign busy_o          = (state_r != S_IDLE);
    assign m_axis_tvalid_o = beat_valid_s;
    assign m_axis_tdata_o  = data_s;
    assign m_axis_tkeep_o  = keep_s;
    assign m_axis_tlast_o  = last_s;

endmodule

// File: tb/tb_keccak_squeeze_unit.sv
// Bench for keccak_squeeze_unit: compares the squeezed stream against the byte-level
// concatenation of supplied rate blocks, with random state delays and backpressure.
module tb_keccak_squeeze_unit;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_i;
    logic [10:0]   rate_i;
    logic [15:0]   out_len_i;
    logic [1599:0] state_i;
    logic          state_valid_i;
    logic          perm_req_o;
    logic [255:0]  m_axis_tdata_o;
    logic [31:0]   m_axis_tkeep_o;
    logic          m_axis_tvalid_o;
    logic          m_axis_tready_i;
    logic          m_axis_tlast_o;
    logic          busy_o;
    logic          done_o;

    int n_cmp = 0;
    int n_bad = 0;
    logic [1599:0] blocks [16];

    keccak_squeeze_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_i         (start_i),
        .rate_i          (rate_i),
        .out_len_i       (out_len_i),
        .state_i         (state_i),
        .state_valid_i   (state_valid_i),
        .perm_req_o      (perm_req_o),
        .m_axis_tdata_o  (m_axis_tdata_o),
        .m_axis_tkeep_o  (m_axis_tkeep_o),
        .m_axis_tvalid_o (m_axis_tvalid_o),
        .m_axis_tready_i (m_axis_tready_i),
        .m_axis_tlast_o  (m_axis_tlast_o),
        .busy_o          (busy_o),
        .done_o          (done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // mode 0: block j byte i = j*0x80 + i; otherwise random bytes
    task automatic fill_blocks(input int mode);
        for (int j = 0; j < 16; j++) begin
            blocks[j] = '0;
            for (int i = 0; i < 200; i++) begin
                blocks[j][8*i +: 8] = (mode == 0) ? 8'(j*128 + i) : 8'($urandom);
            end
        end
    endtask

    // Reference: output byte p is byte (p mod rb) of block (p / rb).
    task automatic exp_beat(input int b, input int len, input int rb,
                            output logic [255:0] d, output logic [31:0] k, output logic l);
        d = '0;
        k = '0;
        for (int i = 0; i < 32; i++) begin
            int p = 32*b + i;
            if (p < len) begin
                d[8*i +: 8] = blocks[p / rb][8*(p % rb) +: 8];
                k[i] = 1'b1;
            end
        end
        l = (32*(b+1) >= len);
    endtask

    task automatic check_outputs_zero();
        check("rst_tvalid", m_axis_tvalid_o, 0);
        check("rst_tdata",  m_axis_tdata_o, 0);
        check("rst_tkeep",  m_axis_tkeep_o, 0);
        check("rst_tlast",  m_axis_tlast_o, 0);
        check("rst_perm",   perm_req_o, 0);
        check("rst_done",   done_o, 0);
        check("rst_busy",   busy_o, 0);
    endtask

    // One digest; abort_at >= 0 pulls rst_n while beat abort_at is presented.
    task automatic run_digest(input int rate, input int len, input int bp, input int abort_at);
        int rb     = rate / 8;
        int nbeats = (len + 31) / 32;
        int nperm  = (len == 0) ? 0 : (len + rb - 1) / rb - 1;
        int beats  = 0;
        int perms  = 0;
        int blk    = 0;
        int dly    = -1;
        int stalled = 0;
        int done_seen = 0;
        int aborted = 0;
        logic [255:0] hold_d, ed;
        logic [31:0]  hold_k, ek;
        logic         hold_l, el;

        @(negedge clk);
        rate_i = 11'(rate);
        out_len_i = 16'(len);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        if (len > 0) dly = $urandom_range(0, 2);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (perm_req_o) begin
                perms++;
                check("perm_vs_valid", m_axis_tvalid_o, 0);
                dly = $urandom_range(1, 3);
            end
            if (done_o) begin
                check("beat_count", beats, nbeats);
                check("perm_count", perms, nperm);
                done_seen = 1;
            end
            if (m_axis_tvalid_o) begin
                if (stalled != 0) begin
                    check("stall_tdata", m_axis_tdata_o, hold_d);
                    check("stall_tkeep", m_axis_tkeep_o, hold_k);
                    check("stall_tlast", m_axis_tlast_o, hold_l);
                end
                if (abort_at >= 0 && beats == abort_at) begin
                    rst_n = 1'b0;
                    #1;
                    check_outputs_zero();
                    aborted = 1;
                    break;
                end
                m_axis_tready_i = (bp != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (beats >= nbeats) begin
                    check("extra_beat", beats, nbeats);
                    m_axis_tready_i = 1'b1;
                    stalled = 0;
                end else if (m_axis_tready_i) begin
                    exp_beat(beats, len, rb, ed, ek, el);
                    check("tdata", m_axis_tdata_o, ed);
                    check("tkeep", m_axis_tkeep_o, ek);
                    check("tlast", m_axis_tlast_o, el);
                    beats++;
                    stalled = 0;
                end else begin
                    hold_d = m_axis_tdata_o;
                    hold_k = m_axis_tkeep_o;
                    hold_l = m_axis_tlast_o;
                    stalled = 1;
                end
            end else begin
                if (stalled != 0) check("valid_dropped", 0, 1);
                stalled = 0;
                m_axis_tready_i = 1'($urandom_range(0, 1));
            end
            state_valid_i = 1'b0;
            if (dly == 0) begin
                if (blk < 16) state_i = blocks[blk];
                blk++;
                state_valid_i = 1'b1;
                dly = -1;
            end else if (dly > 0) begin
                dly--;
            end
            @(negedge clk);
            if (done_seen != 0) break;
        end
        state_valid_i = 1'b0;
        m_axis_tready_i = 1'b0;
        if (aborted != 0) begin
            @(negedge clk);
            check_outputs_zero();
            rst_n = 1'b1;
        end else if (done_seen == 0) begin
            check("timeout", 0, 1);
        end else begin
            check("done_one_cycle", done_o, 0);
            check("idle_busy", busy_o, 0);
        end
    endtask

    initial begin
        int rates [3] = '{576, 1088, 1344};
        rst_n = 1'b0;
        start_i = 1'b0;
        rate_i = '0;
        out_len_i = '0;
        state_i = '0;
        state_valid_i = 1'b0;
        m_axis_tready_i = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero();
        rst_n = 1'b1;

        fill_blocks(0);
        run_digest(1088, 32, 0, -1);
        run_digest(576, 64, 0, -1);
        run_digest(1344, 200, 0, -1);
        run_digest(1088, 136, 0, -1);
        run_digest(1344, 200, 1, -1);
        run_digest(1344, 0, 0, -1);
        run_digest(1344, 200, 0, 3);
        run_digest(1344, 200, 0, -1);

        for (int t = 0; t < 20; t++) begin
            fill_blocks(1);
            run_digest(rates[$urandom_range(0, 2)], $urandom_range(1, 700), 1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
